download_fw_parser: RTL and testbench

- Next-generation firmware container parser. After an ioctl firmware download into DDR3 completes, it walks the image as a chain of 16-byte "MSX" headers, each followed by payload blocks.
- It builds a per-slot table: valid flag, type, block count and payload address.
- Compared with the current parser it adds: parametrised slot count and geometry, 16-bit block counts, bounds and error checking, synchronous reset, abort-on-new-download, and a working update_request/update_ack handshake.

---
 rtl/download_fw_parser_pkg.sv | 19 +
 rtl/download_fw_parser_hdr_reader.sv | 41 ++++
 rtl/download_fw_parser.sv | 141 ++++++++++++++
 tb/tb_download_fw_parser.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/download_fw_parser_pkg.sv
// MSX: shared types and constants for the MSX firmware container parser.
package MSX;
    localparam logic [23:0] FW_MAGIC = 24'h4D5358;
    localparam int FW_HDR_LEN = 16;

    typedef struct packed {
        logic        valid;
        logic [7:0]  fw_type;
        logic [15:0] block_count;
        logic [27:0] store_address;
    } fw_slot_t;

    typedef enum logic [1:0] {
        ERR_BAD_MAGIC,
        ERR_BAD_ID,
        ERR_DUP_ID,
        ERR_OVERFLOW
    } fw_err_t;
endpackage

// File: rtl/download_fw_parser_hdr_reader.sv
// fw_hdr_reader: issues N consecutive single-byte DDR3 reads and strobes each returned byte with its index.
module fw_hdr_reader #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          abort,
    input  logic          start,
    input  logic          stop,
    input  logic          ready,
    output logic          rd,
    output logic          strobe,
    output logic [IW-1:0] idx
);
    logic pend;

    // Data is valid once the request has been taken and the port reports ready again.
    assign strobe = pend & ~rd & ready;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            rd   <= 1'b0;
            pend <= 1'b0;
            idx  <= '0;
        end else if (start) begin
            rd   <= 1'b1;
            pend <= 1'b1;
            idx  <= '0;
        end else if (rd) begin
            if (ready) rd <= 1'b0;
        end else if (strobe) begin
            if (stop || idx == IW'(N - 1)) begin
                pend <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
                rd  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/download_fw_parser.sv
// download_fw_parser: walks a downloaded MSX firmware image in DDR3 and builds a per-slot table.
module download_fw_parser
    import MSX::*;
#(
    parameter int          MAX_FW_ROM  = 16,
    parameter logic [27:0] BASE_ADDR   = 28'h500000,
    parameter logic [5:0]  FW_INDEX    = 6'd2,
    parameter int          BLOCK_SHIFT = 14,
    parameter int          HDR_LEN     = FW_HDR_LEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ioctl_download,
    input  logic [15:0]                     ioctl_index,
    input  logic [26:0]                     ioctl_addr,
    input  logic                            ddr3_ready,
    input  logic [7:0]                      ddr3_dout,
    output logic [27:0]                     ddr3_addr,
    output logic                            ddr3_rd,
    output logic                            ddr3_request,
    input  logic                            update_ack,
    output logic                            update_request,
    output fw_slot_t [MAX_FW_ROM-1:0]       fw_store,
    output logic [7:0]                      entry_count,
    output logic [3:0]                      err_flags,
    output logic                            busy
);
    localparam int SW = $clog2(MAX_FW_ROM);

    typedef enum logic [2:0] {IDLE, CLEAN, HDR_REQ, HDR_WAIT, COMMIT, NOTIFY} state_t;

    state_t        state, state_nx;
    logic          dl_prev, start, abort, hdr_over, rd_start, strobe, bad_magic, hdr_done;
    logic          entry_over, id_bad, unused;
    logic [2:0]    hdr_byte;
    logic [7:0]    hdr_id, hdr_type, magic_byte;
    logic [15:0]   hdr_blk;
    logic [27:0]   offset, image_size;
    logic [39:0]   eoe;
    logic [SW-1:0] clean_idx, slot;

    assign unused     = &{1'b0, ioctl_index[15:6]};
    assign abort      = ioctl_download && state != IDLE;
    assign start      = state == IDLE && dl_prev && !ioctl_download && ioctl_index[5:0] == FW_INDEX;
    assign hdr_over   = {1'b0, offset} + 29'(HDR_LEN) > {1'b0, image_size};
    assign rd_start   = state == HDR_REQ && !hdr_over && ddr3_ready && !ddr3_rd;
    assign magic_byte = hdr_byte[1:0] == 2'd0 ? FW_MAGIC[23:16] : hdr_byte[1:0] == 2'd1 ? FW_MAGIC[15:8] : FW_MAGIC[7:0];
    assign bad_magic  = state == HDR_WAIT && strobe && hdr_byte < 3'd3 && ddr3_dout != magic_byte;
    assign hdr_done   = state == HDR_WAIT && strobe && hdr_byte == 3'd7;
    // 40-bit so a 16-bit block count shifted by BLOCK_SHIFT cannot wrap before the bounds check.
    assign eoe        = 40'(offset) + 40'(HDR_LEN) + (40'(hdr_blk) << BLOCK_SHIFT);
    assign entry_over = eoe > 40'(image_size);
    assign id_bad     = {1'b0, hdr_id} >= 9'(MAX_FW_ROM);
    assign slot       = hdr_id[SW-1:0];

    assign ddr3_addr      = BASE_ADDR + offset + 28'(hdr_byte);
    assign busy           = state inside {CLEAN, HDR_REQ, HDR_WAIT, COMMIT};
    assign ddr3_request   = busy;
    assign update_request = state == NOTIFY;

    fw_hdr_reader #(.N(8)) u_reader (
        .clk    (clk),
        .reset  (reset),
        .abort  (abort),
        .start  (rd_start),
        .stop   (bad_magic),
        .ready  (ddr3_ready),
        .rd     (ddr3_rd),
        .strobe (strobe),
        .idx    (hdr_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start) state_nx = CLEAN;
            CLEAN:    if (clean_idx == SW'(MAX_FW_ROM - 1)) state_nx = HDR_REQ;
            HDR_REQ:  state_nx = hdr_over ? NOTIFY : rd_start ? HDR_WAIT : HDR_REQ;
            HDR_WAIT: state_nx = bad_magic ? NOTIFY : hdr_done ? COMMIT : HDR_WAIT;
            COMMIT:   state_nx = entry_over ? NOTIFY : HDR_REQ;
            NOTIFY:   if (update_ack) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_prev     <= 1'b0;
            offset      <= '0;
            image_size  <= '0;
            clean_idx   <= '0;
            hdr_id      <= '0;
            hdr_type    <= '0;
            hdr_blk     <= '0;
            entry_count <= '0;
            err_flags   <= '0;
            fw_store    <= '0;
        end else begin
            dl_prev <= ioctl_download;
            if (start) begin
                offset      <= '0;
                image_size  <= {1'b0, ioctl_addr} + 28'd1;
                clean_idx   <= '0;
                entry_count <= '0;
                err_flags   <= '0;
            end
            if (!abort && state == CLEAN) begin
                fw_store[clean_idx] <= '0;
                clean_idx           <= clean_idx + 1'b1;
            end
            if (bad_magic) err_flags[ERR_BAD_MAGIC] <= 1'b1;
            if (!abort && state == HDR_WAIT && strobe) begin
                if (hdr_byte == 3'd4) hdr_id <= ddr3_dout;
                if (hdr_byte == 3'd5) hdr_type <= ddr3_dout;
                if (hdr_byte == 3'd6) hdr_blk[7:0] <= ddr3_dout;
                if (hdr_byte == 3'd7) hdr_blk[15:8] <= ddr3_dout;
            end
            if (!abort && state == COMMIT) begin
                if (entry_over) begin
                    err_flags[ERR_OVERFLOW] <= 1'b1;
                end else begin
                    offset <= eoe[27:0];
                    if (id_bad) begin
                        err_flags[ERR_BAD_ID] <= 1'b1;
                    end else begin
                        if (fw_store[slot].valid) err_flags[ERR_DUP_ID] <= 1'b1;
                        fw_store[slot] <= '{valid: 1'b1, fw_type: hdr_type, block_count: hdr_blk,
                                            store_address: BASE_ADDR + offset + 28'(HDR_LEN)};
                        entry_count    <= entry_count + 8'(entry_count != 8'hFF);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_download_fw_parser.sv
// tb_download_fw_parser: directed scenarios against a byte-addressed DDR3 image model.
module tb_download_fw_parser;
    import MSX::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ioctl_download = 1'b0;
    logic [15:0]     ioctl_index = '0;
    logic [26:0]     ioctl_addr = '0;
    logic            ddr3_ready;
    logic [7:0]      ddr3_dout;
    logic [27:0]     ddr3_addr;
    logic            ddr3_rd, ddr3_request, update_request, busy;
    logic            update_ack = 1'b0;
    fw_slot_t [15:0] fw_store;
    logic [7:0]      entry_count;
    logic [3:0]      err_flags;

    int   vectors = 0;
    int   miscompares = 0;
    int   rd_cnt = 0;
    logic slow = 1'b0;
    logic [7:0] mem [0:65535];

    download_fw_parser dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ddr3_ready     (ddr3_ready),
        .ddr3_dout      (ddr3_dout),
        .ddr3_addr      (ddr3_addr),
        .ddr3_rd        (ddr3_rd),
        .ddr3_request   (ddr3_request),
        .update_ack     (update_ack),
        .update_request (update_request),
        .fw_store       (fw_store),
        .entry_count    (entry_count),
        .err_flags      (err_flags),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // DDR3 responder: a request taken while ready returns its byte on the next cycle; slow mode toggles ready.
    always @(posedge clk) begin
        if (reset) begin
            ddr3_ready <= 1'b1;
            ddr3_dout  <= '0;
        end else begin
            if (ddr3_rd && ddr3_ready) begin
                ddr3_dout <= mem[16'(ddr3_addr - 28'h500000)];
                rd_cnt    <= rd_cnt + 1;
            end
            ddr3_ready <= slow ? ~ddr3_ready : 1'b1;
        end
    end

    task automatic put_hdr(input logic [15:0] off, input logic [7:0] m1, input logic [7:0] id,
                           input logic [7:0] typ, input logic [15:0] blk);
        mem[off]         = 8'h4D;
        mem[off + 16'd1] = m1;
        mem[off + 16'd2] = 8'h58;
        mem[off + 16'd3] = 8'h01;
        mem[off + 16'd4] = id;
        mem[off + 16'd5] = typ;
        mem[off + 16'd6] = blk[7:0];
        mem[off + 16'd7] = blk[15:8];
    endtask

    task automatic launch(input logic [27:0] size);
        @(negedge clk);
        ioctl_index    = 16'h0002;
        ioctl_addr     = 27'(size - 28'd1);
        ioctl_download = 1'b1;
        @(negedge clk);
        ioctl_download = 1'b0;
    endtask

    task automatic wait_notify(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = update_request;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        update_ack = 1'b1;
        @(negedge clk);
        update_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ddr3_rd, update_request, busy, ddr3_request} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {ddr3_rd, update_request, busy, ddr3_request});
        end
        vectors++;
        if ({entry_count, err_flags} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_counts: got %h expected 000", {entry_count, err_flags});
        end
        vectors++;
        if (fw_store !== '0) begin
            miscompares++;
            $display("FAIL reset_table: got %h expected 0", fw_store);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        put_hdr(16'h0000, "S", 8'd1, 8'd3, 16'd2);
        launch(28'h8010);
        @(negedge clk);
        vectors++;
        if ({busy, ddr3_request} !== 2'b11) begin
            miscompares++;
            $display("FAIL single_busy: got %b expected 11", {busy, ddr3_request});
        end
        wait_notify(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_notify: got timeout expected update_request");
        end
        vectors++;
        if (fw_store[1] !== {1'b1, 8'd3, 16'd2, 28'h500010}) begin
            miscompares++;
            $display("FAIL single_slot1: got %h expected %h", fw_store[1], {1'b1, 8'd3, 16'd2, 28'h500010});
        end
        vectors++;
        if ({entry_count, err_flags} !== {8'd1, 4'b0000}) begin
            miscompares++;
            $display("FAIL single_counts: got %h expected 010", {entry_count, err_flags});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (update_request !== 1'b1) begin
            miscompares++;
            $display("FAIL single_hold: got %b expected 1", update_request);
        end
        ack();
        vectors++;
        if ({update_request, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_ack: got %b expected 00", {update_request, busy});
        end
    endtask

    task automatic test_chain();
        bit ok;
        slow = 1'b1;
        put_hdr(16'h0000, "S", 8'd0, 8'd4, 16'd1);
        put_hdr(16'h4010, "S", 8'd5, 8'd6, 16'd0);
        launch(28'h4020);
        wait_notify(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL chain_notify: got timeout expected update_request");
        end
        vectors++;
        if (fw_store[0] !== {1'b1, 8'd4, 16'd1, 28'h500010}) begin
            miscompares++;
            $display("FAIL chain_slot0: got %h expected %h", fw_store[0], {1'b1, 8'd4, 16'd1, 28'h500010});
        end
        vectors++;
        if (fw_store[5] !== {1'b1, 8'd6, 16'd0, 28'h504020}) begin
            miscompares++;
            $display("FAIL chain_slot5: got %h expected %h", fw_store[5], {1'b1, 8'd6, 16'd0, 28'h504020});
        end
        vectors++;
        if (fw_store[1].valid !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_clean: got %b expected 0", fw_store[1].valid);
        end
        vectors++;
        if ({entry_count, err_flags} !== {8'd2, 4'b0000}) begin
            miscompares++;
            $display("FAIL chain_counts: got %h expected 020", {entry_count, err_flags});
        end
        ack();
        slow = 1'b0;
    endtask

    task automatic test_bad_magic();
        bit ok;
        int r0;
        put_hdr(16'h0000, "Q", 8'd1, 8'd1, 16'd1);
        r0 = rd_cnt;
        launch(28'h0010);
        wait_notify(ok);
        repeat (5) @(negedge clk);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL magic_notify: got timeout expected update_request");
        end
        vectors++;
        if ({entry_count, err_flags} !== {8'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL magic_counts: got %h expected 001", {entry_count, err_flags});
        end
        vectors++;
        if (fw_store !== '0) begin
            miscompares++;
            $display("FAIL magic_table: got %h expected 0", fw_store);
        end
        vectors++;
        if (rd_cnt - r0 != 2) begin
            miscompares++;
            $display("FAIL magic_reads: got %0d expected 2", rd_cnt - r0);
        end
        ack();
    endtask

    task automatic test_bad_id();
        bit ok;
        put_hdr(16'h0000, "S", 8'd20, 8'd1, 16'd0);
        put_hdr(16'h0010, "S", 8'd2, 8'd7, 16'd0);
        launch(28'h0020);
        wait_notify(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL badid_notify: got timeout expected update_request");
        end
        vectors++;
        if ({entry_count, err_flags} !== {8'd1, 4'b0010}) begin
            miscompares++;
            $display("FAIL badid_counts: got %h expected 012", {entry_count, err_flags});
        end
        vectors++;
        if (fw_store[2] !== {1'b1, 8'd7, 16'd0, 28'h500020}) begin
            miscompares++;
            $display("FAIL badid_slot2: got %h expected %h", fw_store[2], {1'b1, 8'd7, 16'd0, 28'h500020});
        end
        vectors++;
        if (fw_store[4].valid !== 1'b0) begin
            miscompares++;
            $display("FAIL badid_alias: got %b expected 0", fw_store[4].valid);
        end
        ack();
    endtask

    task automatic test_overflow();
        bit ok;
        put_hdr(16'h0000, "S", 8'd1, 8'd3, 16'd4);
        launch(28'h8010);
        wait_notify(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovf_notify: got timeout expected update_request");
        end
        vectors++;
        if ({entry_count, err_flags, fw_store[1].valid} !== {8'd0, 4'b1000, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_state: got %h expected 010", {entry_count, err_flags, fw_store[1].valid});
        end
        ack();
    endtask

    task automatic test_dup();
        bit ok;
        put_hdr(16'h0000, "S", 8'd3, 8'd1, 16'd0);
        put_hdr(16'h0010, "S", 8'd3, 8'd9, 16'd0);
        launch(28'h0020);
        wait_notify(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL dup_notify: got timeout expected update_request");
        end
        vectors++;
        if ({entry_count, err_flags} !== {8'd2, 4'b0100}) begin
            miscompares++;
            $display("FAIL dup_counts: got %h expected 024", {entry_count, err_flags});
        end
        vectors++;
        if (fw_store[3] !== {1'b1, 8'd9, 16'd0, 28'h500020}) begin
            miscompares++;
            $display("FAIL dup_slot3: got %h expected %h", fw_store[3], {1'b1, 8'd9, 16'd0, 28'h500020});
        end
        ack();
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        bit bad = 1'b0;
        put_hdr(16'h0000, "S", 8'd1, 8'd3, 16'd2);
        launch(28'h8010);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = ddr3_rd;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL abort_rd_seen: got timeout expected ddr3_rd");
        end
        ioctl_download = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ddr3_rd, busy, update_request} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_stop: got %b expected 000", {ddr3_rd, busy, update_request});
        end
        ioctl_index = 16'h0000;
        repeat (2) @(negedge clk);
        ioctl_download = 1'b0;
        repeat (40) begin
            @(negedge clk);
            bad |= busy | update_request;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL abort_idle: got activity expected idle");
        end
    endtask

    task automatic test_reset_notify();
        bit ok;
        put_hdr(16'h0000, "S", 8'd6, 8'd2, 16'd0);
        launch(28'h0010);
        wait_notify(ok);
        vectors++;
        if (!ok || fw_store[6] !== {1'b1, 8'd2, 16'd0, 28'h500010}) begin
            miscompares++;
            $display("FAIL rstn_pre: got %b/%h expected 1/%h", ok, fw_store[6], {1'b1, 8'd2, 16'd0, 28'h500010});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({update_request, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstn_req: got %b expected 00", {update_request, busy});
        end
        vectors++;
        if (fw_store !== '0 || entry_count !== 8'd0) begin
            miscompares++;
            $display("FAIL rstn_table: got %h/%h expected 0/00", fw_store, entry_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[16'(i)] = 8'h00;
        test_reset();
        test_single();
        test_chain();
        test_bad_magic();
        test_bad_id();
        test_overflow();
        test_dup();
        test_abort();
        test_reset_notify();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
